std_fp_sacc_pipe: RTL
=====================

// Module: std_fp_sacc_pipe
// PURPOSE
//   Signed fixed-point accumulator that consumes the product stream of the signed
//   fixed-point multiplier; together they form a MAC for dot-product and FIR kernels.
//   Each go/done operation adds one WIDTH-bit input into a guarded internal sum,
//   or loads it when clear is set. Drives a saturated WIDTH-bit result and a sticky
//   overflow flag. Uses the standard go/done multi-cycle primitive handshake.
// PARAMETERS
//   WIDTH       32  total bits of in/out (two's complement)
//   INT_WIDTH   16  integer bits incl. sign; kept for format consistency, no arithmetic effect
//   FRAC_WIDTH  16  fraction bits; INT_WIDTH+FRAC_WIDTH == WIDTH
//   GUARD        8  extra MSBs in internal accumulator; ACC_W = WIDTH+GUARD
// PORTS
//   clk    in   1      clock; all state updates on posedge
//   reset  in   1      synchronous active-high reset
//   go     in   1      start/hold operation; held high by controller until done
//   clear  in   1      sampled with go in IDLE: 1 = load (acc := in), 0 = add
//   in     in   WIDTH  signed fixed-point operand, sampled on go in IDLE
//   out    out  WIDTH  saturated accumulator value, registered
//   ovf    out  1      sticky: saturation has occurred since last clear/reset
//   done   out  1      one-cycle pulse; result valid
// BEHAVIOUR
//   Reset (sync, priority over all): state=IDLE, acc=0, out=0, ovf=0, done=0, in_q=0.
//   States: IDLE -> ADD -> DONE -> IDLE.
//   IDLE: go=1 -> in_q<=in, clr_q<=clear, goto ADD. go=0 -> stay; done=0.
//   ADD:  go=1 -> compute (below), register acc/out/ovf, done<=1, goto DONE.
//         go=0 (abort) -> goto IDLE; acc, out, ovf unchanged; done stays 0.
//   DONE: done=1 this cycle only; done<=0, goto IDLE unconditionally.
//         If go is still high in the following IDLE cycle, a new op starts (back-to-back).
//   Latency: go first sampled at edge N -> done high in the cycle after edge N+1.
//            Throughput is one op per 3 cycles.
//   Arithmetic, in the ADD cycle:
//     ext    = in_q sign-extended to ACC_W
//     sum    = clr_q ? ext : acc + ext, computed at ACC_W+1 bits
//     acc_n  = sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]
//     out_n  = acc_n clamped to [0x80..0 (min WIDTH), 0x7F..F (max WIDTH)]
//     ovf_n  = (clr_q ? 0 : ovf) | (sum clamped) | (acc_n clamped)
//   acc keeps GUARD headroom: the out value can saturate and later recover
//   once acc falls back into WIDTH range; ovf stays set.
//   out and ovf hold their values between ops. Only load, reset or a completed add
//   changes them.
//   Binary point is implicit. Aligned formats mean no shift or rounding.
//   Reset asserted in any state, including mid-op: immediate return to reset values,
//   with no done pulse.
//   go/clear/in changes while in ADD or DONE are ignored, except a go=0 abort in ADD.
// TESTING  (WIDTH=32, INT_WIDTH=16, FRAC_WIDTH=16, GUARD=8)
//   1. Load 0x0001_8000 (1.5, clear=1), then add 0x0001_8000 twice
//      -> out 0x0001_8000, 0x0003_0000, 0x0004_8000; ovf=0; each done two cycles after go.
//   2. Load 0x0001_0000, then add 0xFFFD_C000 (-2.25)
//      -> out 0xFFFE_C000 (-1.25), ovf=0.
//   3. Load 0x7FFF_0000, then add 0x7FFF_0000 -> out 0x7FFF_FFFF, ovf=1.
//      Add 0x8000_0000 -> out 0x7FFE_0000, ovf still 1.
//   4. With ovf=1, load 0x0000_4000 -> out 0x0000_4000, ovf=0.
//   5. Drop go in the ADD cycle with in=0x0001_0000
//      -> no done, out unchanged; next full op adds correctly.
//   6. Assert reset in the ADD cycle -> next cycle out=0, ovf=0, done=0, IDLE.
//      Back-to-back go held high gives done every 3rd cycle.

Source files
------------

// File: rtl/std_fp_sacc_pipe.sv
// Signed fixed-point saturating accumulator with go/done handshake.
// A guarded internal sum feeds a WIDTH-bit saturated output and a sticky overflow flag.
module std_fp_sacc_pipe #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int GUARD      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             done
);
    localparam int ACC_W = WIDTH + GUARD;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
        $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_in_q;
    logic               r_clr_q;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH-1:0]   r_out;
    logic               r_ovf;
    logic               r_done;

    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_sum_sat;
    logic [ACC_W-1:0]   w_acc_n;
    logic [GUARD:0]     w_top;
    logic               w_out_sat;
    logic [WIDTH-1:0]   w_out_n;
    logic               w_ovf_n;
    logic               w_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: if (go) w_state_next = S_ADD;
            S_ADD: begin
                // Dropping go here aborts without touching the accumulator.
                w_state_next = go ? S_DONE : S_IDLE;
                w_commit     = go;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ext     = {{GUARD{r_in_q[WIDTH-1]}}, r_in_q};
        w_sum     = r_clr_q ? {w_ext[ACC_W-1], w_ext}
                            : ({r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext});
        w_sum_sat = w_sum[ACC_W] != w_sum[ACC_W-1];
        w_acc_n   = w_sum_sat ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
        // The value fits WIDTH bits only if the guard bits plus the WIDTH sign agree.
        w_top     = w_acc_n[ACC_W-1:WIDTH-1];
        w_out_sat = !((&w_top) || (~|w_top));
        w_out_n   = w_out_sat ? (w_acc_n[ACC_W-1] ? OUT_MIN : OUT_MAX) : w_acc_n[WIDTH-1:0];
        w_ovf_n   = (~r_clr_q & r_ovf) | w_sum_sat | w_out_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q  <= '0;
            r_clr_q <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (r_state == S_IDLE && go) begin
                r_in_q  <= in;
                r_clr_q <= clear;
            end
            if (w_commit) begin
                r_acc <= w_acc_n;
                r_out <= w_out_n;
                r_ovf <= w_ovf_n;
            end
        end
    end

    assign out  = r_out;
    assign ovf  = r_ovf;
    assign done = r_done;
endmodule
